cpu_mem_bridge: RTL
===================

// Module: cpu_mem_bridge
// PURPOSE
//  Parametrised CPU load/store to Wishbone (pipelined) bridge. Sits between the core's LSU and the memory bus.
//  Adds write-lane steering, split transactions for misaligned accesses, bus error and timeout reporting,
//  and a configurable bus data width. A byte, half or word access costs one or two bus beats.
// PARAMETERS
//  ADDR_W         32   byte address width on the CPU side; o_wb_addr is a word address of the same width
//  DATA_W         32   bus data width, 32 or 64; BYTES=DATA_W/8, OFFS=log2(BYTES)
//  MISALIGN_SPLIT 1    1: an access crossing a bus word is split into two beats; 0: it returns o_err with no bus cycle
//  TIMEOUT        255  max cycles per beat in REQ+WAIT before abort; 0 disables the timeout
// PORTS
//  i_clk       in   1        clock, rising edge
//  i_reset_n   in   1        asynchronous active-low reset
//  i_stb       in   1        CPU request strobe
//  i_we        in   1        1=store, 0=load
//  i_addr      in   ADDR_W   byte address
//  i_wdata     in   32       store data, right-aligned
//  i_size      in   3        000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; all other codes are illegal
//  o_stall     out  1        high when a request cannot be accepted
//  o_ack       out  1        one-cycle pulse: access done
//  o_err       out  1        one-cycle pulse: access failed (illegal size, misaligned with split off, bus err, timeout)
//  o_rdata     out  32       load result, extended per i_size; held until the next o_ack
//  o_wb_cyc    out  1        bus cycle
//  o_wb_stb    out  1        bus strobe
//  o_wb_we     out  1        bus write enable
//  o_wb_addr   out  ADDR_W   word address (byte addr >> OFFS)
//  o_wb_data   out  DATA_W   lane-steered write data
//  o_wb_sel    out  BYTES    byte lane enables
//  i_wb_data   in   DATA_W   read data
//  i_wb_ack    in   1        slave ack
//  i_wb_stall  in   1        slave stall
//  i_wb_err    in   1        slave error
// BEHAVIOUR
//  Reset (i_reset_n=0, async): state IDLE; all outputs 0. A beat in flight is abandoned: cyc/stb drop at once, no ack/err.
//  States: IDLE, REQ1, WAIT1, REQ2, WAIT2. o_stall = (state!=IDLE).
//  IDLE: on i_stb, latch addr/we/size/wdata. Size 1/2/4 bytes, off = addr[OFFS-1:0], split = off+size > BYTES.
//   Illegal size, or split with MISALIGN_SPLIT=0: pulse o_err next cycle, stay IDLE, no bus cycle. Otherwise go to REQ1.
//  REQx: cyc=stb=1. Address, sel and data are stable. When !i_wb_stall, go to WAITx and drop stb on the next cycle.
//  WAITx: cyc=1, stb=0.
//   On i_wb_err: drop cyc, pulse o_err, go to IDLE; the second beat is never issued.
//   On i_wb_ack: capture lanes, then REQ2 if split and beat 1, else drop cyc, pulse o_ack, go to IDLE.
//   Ack and err in the same cycle: err wins.
//  Beat 1: addr = addr>>OFFS; sel = low bytes starting at lane off, clipped at BYTES. Beat 2: addr+1; sel = remaining bytes from lane 0.
//  o_wb_cyc stays high between beats (REQ2 follows WAIT1 directly). Word address wraps modulo 2^ADDR_W.
//  Write data: byte k of i_wdata goes to lane (off+k) mod BYTES; unused lanes are 0.
//  Read data: gathered bytes are little-endian (beat-1 lanes first), then sign-extended (000/001) or zero-extended (1xx).
//  Timeout: counter clears on entering each REQx and counts REQ+WAIT cycles.
//   At TIMEOUT: drop cyc/stb, pulse o_err, go to IDLE. A late ack is ignored because cyc is low.
//  o_ack/o_err are asserted in the first IDLE cycle, so a new request may be accepted in that same cycle (back-to-back).
//  Latency (no stall, ack next cycle): aligned access ack 3 cycles after accept; split access 5 cycles.
// TESTING (DATA_W=32, TIMEOUT=16)
//  1 lw 0x100; mem[0x40]=0x80FF1234 -> one beat addr 0x40 sel 1111; o_rdata=0x80FF1234, single o_ack.
//  2 lb 0x103 then lbu 0x103; same word -> sel 1000; o_rdata=0xFFFFFF80, then 0x00000080.
//  3 sh 0x107, wdata 0x0000ABCD -> beat addr 0x41 sel 1000 data[31:24]=0xCD, then 0x42 sel 0001 data[7:0]=0xAB;
//    cyc held across both beats, one o_ack.
//  4 lw 0x102; mem[0x40]=0x11223344, mem[0x41]=0x55667788 -> two beats, o_rdata=0x77881122; stall 3 cycles on beat 2 -> same result.
//  5 Slave never acks -> cyc drops after 16 cycles, o_err pulse, no o_ack.
//    i_wb_err on beat 1 of a split -> no beat 2, o_err.
//  6 i_reset_n low during WAIT1 -> cyc/stb low immediately, no ack after release.
//    i_size=011 -> o_err next cycle, cyc never asserted.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// CPU load/store to pipelined Wishbone bridge: lane steering, split misaligned
// accesses into two beats, bus error and per-beat timeout reporting.
module cpu_mem_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MISALIGN_SPLIT = 1,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [2:0]            i_size,
    output logic                  o_stall,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_W-1:0]     o_wb_addr,
    output logic [DATA_W-1:0]     o_wb_data,
    output logic [DATA_W/8-1:0]   o_wb_sel,
    input  logic [DATA_W-1:0]     i_wb_data,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_err
);

    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned OFFS     = $clog2(BYTES);
    localparam int unsigned WIDE_W   = 2 * DATA_W;
    localparam int unsigned SEL2_W   = 2 * BYTES;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN    = (TIMEOUT != 0);
    localparam bit          SPLIT_EN = (MISALIGN_SPLIT != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_WAIT2 = 3'd4
    } state_e;

    state_e              state_q;
    logic [OFFS-1:0]     off_q;
    logic [2:0]          size_q;
    logic                split_q;
    logic                we_q;
    logic [BYTES-1:0]    sel_hi_q;
    logic [DATA_W-1:0]   data_hi_q;
    logic [DATA_W-1:0]   rd_lo_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cyc_q;
    logic                stb_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [BYTES-1:0]    wb_sel_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                ack_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    logic [OFFS-1:0]     req_off_d;
    logic [2:0]          req_nbytes_d;
    logic [3:0]          req_mask_d;
    logic                req_illegal_d;
    logic                req_split_d;
    logic [31:0]         req_wdata_d;
    logic [SEL2_W-1:0]   req_sel_d;
    logic [WIDE_W-1:0]   req_data_d;
    logic [WIDE_W-1:0]   rd_wide_d;
    logic [31:0]         rd_gather_d;
    logic [31:0]         rd_ext_d;
    logic                timeout_hit_d;

    // Decode a new request: byte count, legality, split and two-beat lane images.
    always_comb begin
        req_off_d     = i_addr[OFFS-1:0];
        req_nbytes_d  = 3'd1;
        req_mask_d    = 4'b0001;
        case (i_size[1:0])
            2'b01:   begin req_nbytes_d = 3'd2; req_mask_d = 4'b0011; end
            2'b10:   begin req_nbytes_d = 3'd4; req_mask_d = 4'b1111; end
            default: begin req_nbytes_d = 3'd1; req_mask_d = 4'b0001; end
        endcase
        req_illegal_d = (i_size[1:0] == 2'b11) || (i_size[2] && i_size[1]);
        req_split_d   = (32'(req_off_d) + 32'(req_nbytes_d)) > BYTES;
        req_wdata_d   = i_wdata & {{8{req_mask_d[3]}}, {8{req_mask_d[2]}},
                                   {8{req_mask_d[1]}}, {8{req_mask_d[0]}}};
        req_sel_d     = SEL2_W'(req_mask_d) << req_off_d;
        req_data_d    = WIDE_W'(req_wdata_d) << {req_off_d, 3'b000};
    end

    // Gather read lanes (beat 1 low, beat 2 high), realign and extend.
    always_comb begin
        if (state_q == ST_WAIT2) begin
            rd_wide_d = {i_wb_data, rd_lo_q};
        end else begin
            rd_wide_d = {DATA_W'(0), i_wb_data};
        end
        rd_gather_d = 32'(rd_wide_d >> {off_q, 3'b000});
        case (size_q)
            3'b000:  rd_ext_d = {{24{rd_gather_d[7]}}, rd_gather_d[7:0]};
            3'b001:  rd_ext_d = {{16{rd_gather_d[15]}}, rd_gather_d[15:0]};
            3'b100:  rd_ext_d = {24'd0, rd_gather_d[7:0]};
            3'b101:  rd_ext_d = {16'd0, rd_gather_d[15:0]};
            default: rd_ext_d = rd_gather_d;
        endcase
        timeout_hit_d = TO_EN && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            off_q     <= '0;
            size_q    <= '0;
            split_q   <= 1'b0;
            we_q      <= 1'b0;
            sel_hi_q  <= '0;
            data_hi_q <= '0;
            rd_lo_q   <= '0;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            wb_addr_q <= '0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_stb) begin
                        off_q   <= req_off_d;
                        size_q  <= i_size;
                        split_q <= req_split_d;
                        we_q    <= i_we;
                        if (req_illegal_d || (req_split_d && !SPLIT_EN)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ1;
                            cyc_q     <= 1'b1;
                            stb_q     <= 1'b1;
                            cnt_q     <= '0;
                            wb_addr_q <= i_addr >> OFFS;
                            wb_sel_q  <= req_sel_d[BYTES-1:0];
                            wb_data_q <= req_data_d[DATA_W-1:0];
                            sel_hi_q  <= req_sel_d[SEL2_W-1:BYTES];
                            data_hi_q <= req_data_d[WIDE_W-1:DATA_W];
                        end
                    end
                end
                ST_REQ1, ST_REQ2: begin
                    if (timeout_hit_d) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!i_wb_stall) begin
                            stb_q   <= 1'b0;
                            state_q <= (state_q == ST_REQ1) ? ST_WAIT1 : ST_WAIT2;
                        end
                    end
                end
                ST_WAIT1, ST_WAIT2: begin
                    // A response in the same cycle as the limit still counts.
                    if (i_wb_err) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (i_wb_ack) begin
                        if (state_q == ST_WAIT1 && split_q) begin
                            rd_lo_q   <= i_wb_data;
                            stb_q     <= 1'b1;
                            cnt_q     <= '0;
                            wb_addr_q <= wb_addr_q + ADDR_W'(1);
                            wb_sel_q  <= sel_hi_q;
                            wb_data_q <= data_hi_q;
                            state_q   <= ST_REQ2;
                        end else begin
                            cyc_q   <= 1'b0;
                            ack_q   <= 1'b1;
                            state_q <= ST_IDLE;
                            if (!we_q) begin
                                rdata_q <= rd_ext_d;
                            end
                        end
                    end else if (timeout_hit_d) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stall   = (state_q != ST_IDLE);
    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_rdata   = rdata_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = wb_addr_q;
    assign o_wb_sel  = wb_sel_q;
    assign o_wb_data = wb_data_q;

endmodule
